// File: rtl/program_loader.sv
// program_loader: UART-side boot loader that runs before the CPU starts.
// Sends the 0x99 request byte and receives a little-endian program size.
// It then receives the program image, packs it into 32-bit little-endian
// words and writes them to instruction memory. Finally it sends the 0xAA
// ready byte.
//
// Optional feature: define PROGRAM_LOADER_CHECKSUM_EN to expect one XOR
// checksum byte after the image. A mismatch latches checksum_error. When
// the macro is undefined, checksum_error is tied to 0.
//
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   start                             pulse that begins a load from IDLE
//   rx_valid, rx_data                 received byte strobe and data
//   tx_ready, tx_valid, tx_data       transmit handshake and byte
//   program_data_size                 received program size in bytes
//   program_data_size_fetch_finished  level, size fully received
//   program_data_fetch_finished       level, image written and 0xAA accepted
//   imem_we, imem_addr, imem_wdata    instruction-memory write port
//   overflow                          sticky, image exceeded memory capacity
//   checksum_error                    sticky, checksum byte mismatch
module program_loader #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned SIZE_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  tx_ready,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    output logic [31:0]           program_data_size,
    output logic                  program_data_size_fetch_finished,
    output logic                  program_data_fetch_finished,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  overflow,
    output logic                  checksum_error
);

    localparam logic [7:0]          REQ_BYTE   = 8'h99;
    localparam logic [7:0]          READY_BYTE = 8'hAA;
    localparam logic [ADDR_WIDTH:0] ONE_WORD   = 1;

    typedef enum logic [2:0] {
        IDLE,
        TX_99,
        RX_SIZE,
        RX_DATA,
        FLUSH,
        TX_AA,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        RX_CSUM,
`endif
        DONE
    } state_t;

    // State entered once the image (and any partial-word flush) is complete.
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_t POST_IMAGE = RX_CSUM;
    localparam logic   POST_IS_TX = 1'b0;
`else
    localparam state_t POST_IMAGE = TX_AA;
    localparam logic   POST_IS_TX = 1'b1;
`endif

    state_t              state;
    logic [1:0]          size_cnt;
    logic [31:0]         byte_cnt;
    logic [31:0]         word_asm;
    // One extra bit so the address saturates at capacity instead of wrapping.
    logic [ADDR_WIDTH:0] word_idx;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]          csum;
`endif

    logic [31:0] size_merged;
    logic [31:0] asm_merged;
    logic [31:0] byte_cnt_inc;
    logic [1:0]  lane;
    logic        last_byte;
    logic        addr_full;

    // Incoming byte merged into the size register and into the word assembler.
    // Lane 0 starts a fresh word, so a flushed partial word has zero upper bytes.
    always_comb begin
        size_merged = program_data_size;
        size_merged[{size_cnt, 3'b000} +: 8] = rx_data;
        lane         = byte_cnt[1:0];
        asm_merged   = (lane == 2'd0) ? 32'd0 : word_asm;
        asm_merged[{lane, 3'b000} +: 8] = rx_data;
        byte_cnt_inc = byte_cnt + 32'd1;
        last_byte    = (byte_cnt_inc == program_data_size);
        addr_full    = word_idx[ADDR_WIDTH];
    end

    // Load sequencer. All outputs are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                            <= IDLE;
            tx_valid                         <= 1'b0;
            tx_data                          <= 8'd0;
            program_data_size                <= 32'd0;
            program_data_size_fetch_finished <= 1'b0;
            program_data_fetch_finished      <= 1'b0;
            imem_we                          <= 1'b0;
            imem_addr                        <= '0;
            imem_wdata                       <= 32'd0;
            overflow                         <= 1'b0;
            size_cnt                         <= 2'd0;
            byte_cnt                         <= 32'd0;
            word_asm                         <= 32'd0;
            word_idx                         <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum                             <= 8'd0;
            checksum_error                   <= 1'b0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= TX_99;
                        tx_valid <= 1'b1;
                        tx_data  <= REQ_BYTE;
                    end
                end
                TX_99: begin
                    if (tx_valid && tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= RX_SIZE;
                    end
                end
                RX_SIZE: begin
                    if (rx_valid) begin
                        program_data_size <= size_merged;
                        size_cnt          <= size_cnt + 2'd1;
                        if (size_cnt == 2'(SIZE_BYTES - 1)) begin
                            program_data_size_fetch_finished <= 1'b1;
                            if (size_merged == 32'd0) begin
                                state    <= POST_IMAGE;
                                tx_valid <= POST_IS_TX;
                                tx_data  <= READY_BYTE;
                            end else begin
                                state <= RX_DATA;
                            end
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_valid) begin
                        word_asm <= asm_merged;
                        byte_cnt <= byte_cnt_inc;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        csum     <= csum ^ rx_data;
`endif
                        // Full word, or the final partial word (written while in FLUSH).
                        if (lane == 2'd3 || last_byte) begin
                            if (addr_full) begin
                                overflow <= 1'b1;
                            end else begin
                                imem_we    <= 1'b1;
                                imem_addr  <= word_idx[ADDR_WIDTH-1:0];
                                imem_wdata <= asm_merged;
                                word_idx   <= word_idx + ONE_WORD;
                            end
                        end
                        if (last_byte) begin
                            if (lane == 2'd3) begin
                                state    <= POST_IMAGE;
                                tx_valid <= POST_IS_TX;
                                tx_data  <= READY_BYTE;
                            end else begin
                                state <= FLUSH;
                            end
                        end
                    end
                end
                FLUSH: begin
                    state    <= POST_IMAGE;
                    tx_valid <= POST_IS_TX;
                    tx_data  <= READY_BYTE;
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                RX_CSUM: begin
                    if (rx_valid) begin
                        if (rx_data != csum) begin
                            checksum_error <= 1'b1;
                        end
                        state    <= TX_AA;
                        tx_valid <= 1'b1;
                        tx_data  <= READY_BYTE;
                    end
                end
`endif
                TX_AA: begin
                    if (tx_valid && tx_ready) begin
                        tx_valid                    <= 1'b0;
                        program_data_fetch_finished <= 1'b1;
                        state                       <= DONE;
                    end
                end
                DONE: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef PROGRAM_LOADER_CHECKSUM_EN
    assign checksum_error = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader. A large instance (default capacity) and a small
// instance (ADDR_WIDTH=2) are both driven with the same byte stream.
// Expected writes and flag timing are derived from the byte stream itself.
module tb_program_loader;

    localparam int unsigned AW0 = 15;
    localparam int unsigned AW1 = 2;
    localparam int NEVER = 1 << 30;

    logic       clk = 1'b0;
    logic       reset, start, rx_valid, tx_ready;
    logic [7:0] rx_data;

    logic           tx_valid0, sfin0, dfin0, we0, ovf0, cerr0;
    logic [7:0]     tx_data0;
    logic [31:0]    size0, wdata0;
    logic [AW0-1:0] addr0;
    logic           tx_valid1, sfin1, dfin1, we1, ovf1, cerr1;
    logic [7:0]     tx_data1;
    logic [31:0]    size1, wdata1;
    logic [AW1-1:0] addr1;

    program_loader #(.ADDR_WIDTH(AW0)) u_dut (
        .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_valid(tx_valid0), .tx_data(tx_data0),
        .program_data_size(size0), .program_data_size_fetch_finished(sfin0),
        .program_data_fetch_finished(dfin0), .imem_we(we0), .imem_addr(addr0),
        .imem_wdata(wdata0), .overflow(ovf0), .checksum_error(cerr0));

    program_loader #(.ADDR_WIDTH(AW1)) u_small (
        .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_valid(tx_valid1), .tx_data(tx_data1),
        .program_data_size(size1), .program_data_size_fetch_finished(sfin1),
        .program_data_fetch_finished(dfin1), .imem_we(we1), .imem_addr(addr1),
        .imem_wdata(wdata1), .overflow(ovf1), .checksum_error(cerr1));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected behaviour
    typedef struct {
        int          cyc;
        int          word;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    int          ptr[2];
    int          cap[2] = '{1 << AW0, 1 << AW1};
    int          ovf_cyc[2];
    int          sfin_cyc, dfin_cyc, cerr_cyc;
    logic [31:0] exp_size;
    bit          idle_zero;
    bit          chk_en = 1'b0;
    logic [31:0] mem[2][8];
    int          wr_cnt[2];
    logic [7:0]  img[$];

    int n_pass = 0;
    int n_total = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic void clear_model();
        exp_wr.delete();
        ptr      = '{0, 0};
        ovf_cyc  = '{NEVER, NEVER};
        wr_cnt   = '{0, 0};
        sfin_cyc = NEVER;
        dfin_cyc = NEVER;
        cerr_cyc = NEVER;
        exp_size = 32'd0;
        idle_zero = 1'b1;
    endfunction

    function automatic void cmp_inst(int k, logic we, logic [31:0] addr, logic [31:0] data,
                                     logic sfin, logic dfin, logic ovf, logic cerr,
                                     logic [31:0] size, logic txv, logic [7:0] txd);
        string p = (k == 0) ? "big" : "small";
        while (ptr[k] < exp_wr.size() && exp_wr[ptr[k]].word >= cap[k]) ptr[k]++;
        if (ptr[k] < exp_wr.size() && exp_wr[ptr[k]].cyc <= cyc) begin
            check({p, ".imem_we"}, 32'(we), 32'd1);
            if (we) begin
                check({p, ".imem_addr"}, addr, 32'(exp_wr[ptr[k]].word));
                check({p, ".imem_wdata"}, data, exp_wr[ptr[k]].data);
            end
            ptr[k]++;
        end else begin
            check({p, ".imem_we"}, 32'(we), 32'd0);
        end
        if (we) begin
            mem[k][addr[2:0]] = data;
            wr_cnt[k]++;
        end
        check({p, ".size_fetch_finished"}, 32'(sfin), 32'(cyc >= sfin_cyc));
        check({p, ".fetch_finished"}, 32'(dfin), 32'(cyc >= dfin_cyc));
        check({p, ".overflow"}, 32'(ovf), 32'(cyc >= ovf_cyc[k]));
        check({p, ".checksum_error"}, 32'(cerr), 32'(cyc >= cerr_cyc));
        if (cyc >= sfin_cyc) check({p, ".program_data_size"}, size, exp_size);
        if (idle_zero) begin
            check({p, ".idle_size"}, size, 32'd0);
            check({p, ".idle_tx_valid"}, 32'(txv), 32'd0);
            check({p, ".idle_tx_data"}, 32'(txd), 32'd0);
        end
    endfunction

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_inst(0, we0, 32'(addr0), wdata0, sfin0, dfin0, ovf0, cerr0, size0, tx_valid0, tx_data0);
            cmp_inst(1, we1, 32'(addr1), wdata1, sfin1, dfin1, ovf1, cerr1, size1, tx_valid1, tx_data1);
        end
    end

    // All driver tasks are entered and left 1 time unit after a rising edge.
    task automatic do_reset();
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; tx_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        clear_model();
        chk_en = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idle_zero = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output int vis);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        vis = cyc;
    endtask

    task automatic send_size(input logic [31:0] sz);
        int vis;
        logic [31:0] s;
        s = sz;
        for (int i = 0; i < 4; i++) begin
            send_byte(s[7:0], vis);
            s = s >> 8;
        end
        sfin_cyc = vis;
        exp_size = sz;
    endtask

    // Sends the image in img; csum_override < 0 sends the correct checksum.
    task automatic send_image(input int csum_override);
        int vis;
        logic [31:0] w;
        logic [7:0]  x;
        int n;
        n = img.size();
        w = 32'd0;
        x = 8'd0;
        for (int i = 0; i < n; i++) begin
            send_byte(img[i], vis);
            w = w | (32'(img[i]) << (8 * (i % 4)));
            x = x ^ img[i];
            if (i % 4 == 3 || i == n - 1) begin
                exp_wr.push_back('{cyc: vis, word: i / 4, data: w});
                for (int k = 0; k < 2; k++)
                    if (i / 4 >= cap[k] && ovf_cyc[k] == NEVER) ovf_cyc[k] = vis;
                w = 32'd0;
            end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        @(posedge clk); #1;
        if (csum_override >= 0) begin
            send_byte(8'(csum_override), vis);
            if (8'(csum_override) != x) cerr_cyc = vis;
        end else begin
            send_byte(x, vis);
        end
`else
        if (csum_override > 255) $display("note: checksum override ignored");
`endif
    endtask

    task automatic tx_handshake(input logic [7:0] b, input int delay, input bit is_ready,
                                output int waited);
        waited = 0;
        while (!(tx_valid0 && tx_valid1) && waited < 30) begin
            @(posedge clk); #1;
            waited++;
        end
        check("tx_valid_rise", {30'd0, tx_valid0, tx_valid1}, 32'd3);
        check("tx_data", {16'd0, tx_data0, tx_data1}, {16'd0, b, b});
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            check("tx_valid_held", {30'd0, tx_valid0, tx_valid1}, 32'd3);
            check("tx_data_held", {16'd0, tx_data0, tx_data1}, {16'd0, b, b});
        end
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        if (is_ready) dfin_cyc = cyc;
        check("tx_single_transfer", {30'd0, tx_valid0, tx_valid1}, 32'd0);
    endtask

    task automatic run_load(input logic [31:0] sz, input int csum_override, output int waited);
        int w99;
        do_start();
        tx_handshake(8'h99, 0, 1'b0, w99);
        send_size(sz);
        send_image(csum_override);
        tx_handshake(8'hAA, 0, 1'b1, waited);
        @(posedge clk); #1;
    endtask

    initial begin
        int waited;
        int vis;
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        int vis;
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        @(posedge clk); #1;
        check("reset.tx_valid", 32'(tx_valid0), 32'd0);
        check("reset.size", size0, 32'd0);

        // 0x99 held through 5 cycles of tx_ready low, then 8-byte image
        do_start();
        tx_handshake(8'h99, 5, 1'b0, waited);
        send_size(32'd8);
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        send_image(-1);
        tx_handshake(8'hAA, 0, 1'b1, waited);
        @(posedge clk); #1;
        check("t8.aa_latency", 32'(waited), 32'd0);
        check("t8.word0", mem[0][0], 32'h0000_0013);
        check("t8.word1", mem[0][1], 32'h0010_0093);
        check("t8.writes", 32'(wr_cnt[0]), 32'd2);
        check("t8.size", size0, 32'd8);
        check("t8.done", 32'(dfin0), 32'd1);

        // Partial final word goes through FLUSH
        do_reset();
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        run_load(32'd6, -1, waited);
        check("t6.word0", mem[0][0], 32'h4433_2211);
        check("t6.word1", mem[0][1], 32'h0000_6655);
        check("t6.writes", 32'(wr_cnt[0]), 32'd2);

        // Zero-size image
        do_reset();
        img.delete();
        run_load(32'd0, -1, waited);
        check("t0.aa_latency", 32'(waited), 32'd0);
        check("t0.writes", 32'(wr_cnt[0]), 32'd0);
        check("t0.flags", {30'd0, sfin0, dfin0}, 32'd3);

        // 20 bytes: the small instance holds only 4 words
        do_reset();
        img.delete();
        for (int i = 0; i < 20; i++) img.push_back(8'(i + 1));
        run_load(32'd20, -1, waited);
        check("t20.small_writes", 32'(wr_cnt[1]), 32'd4);
        check("t20.big_writes", 32'(wr_cnt[0]), 32'd5);
        check("t20.small_word3", mem[1][3], 32'h100F_0E0D);
        check("t20.overflow", {30'd0, ovf0, ovf1}, 32'd1);
        check("t20.small_done", 32'(dfin1), 32'd1);

        // Reset mid-image aborts the load; bytes in IDLE are ignored
        do_reset();
        do_start();
        tx_handshake(8'h99, 0, 1'b0, waited);
        send_size(32'd8);
        for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i), vis);
        do_reset();
        check("abort.size", size0, 32'd0);
        check("abort.flags", {28'd0, sfin0, dfin0, we0, ovf0}, 32'd0);
        for (int i = 0; i < 4; i++) send_byte(8'h5A, vis);
        @(posedge clk); #1;
        check("abort.writes", 32'(wr_cnt[0]), 32'd0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        do_reset();
        img = '{8'h01, 8'h02, 8'h04, 8'h08};
        run_load(32'd4, 8'h0F, waited);
        check("csum.good", 32'(cerr0), 32'd0);
        do_reset();
        run_load(32'd4, 8'h0E, waited);
        check("csum.bad", 32'(cerr0), 32'd1);
        check("csum.bad_done", 32'(dfin0), 32'd1);
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
